sd_cmd_master: RTL and testbench

- Command-path sequencer directly downstream of the Wishbone register bank.
- Consumes cmd_start, the argument, command and timeout registers; drives one command transaction on the serial command PHY (sd_cmd_serial_host).
- Returns the response words and command interrupt status to the register bank, which exposes them as resp0..resp3 and cmd_isr.

---
 rtl/sd_cmd_master_if.sv | 45 ++++
 rtl/sd_cmd_master.sv | 181 ++++++++++++++++++
 tb/tb_sd_cmd_master.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_master_if.sv
// Command-path bundle between the register bank / serial PHY and sd_cmd_master.
// master modport is the sequencer view; slave modport is the environment (bank + PHY) view.
interface sd_cmd_master_if #(
    parameter int CMD_REG_SIZE  = 14,
    parameter int CMD_TIMEOUT_W = 24,
    parameter int INT_CMD_SIZE  = 5
);
    logic                     cmd_start_i;
    logic [31:0]              argument_i;
    logic [CMD_REG_SIZE-1:0]  command_i;
    logic [CMD_TIMEOUT_W-1:0] timeout_i;
    logic                     int_status_rst_i;
    logic                     start_xfr_o;
    logic                     go_idle_o;
    logic [39:0]              cmd_o;
    logic                     with_response_o;
    logic                     long_response_o;
    logic                     finish_i;
    logic                     crc_ok_i;
    logic                     index_ok_i;
    logic [119:0]             response_i;
    logic                     dat0_i;
    logic [31:0]              response_0_o;
    logic [31:0]              response_1_o;
    logic [31:0]              response_2_o;
    logic [31:0]              response_3_o;
    logic [INT_CMD_SIZE-1:0]  int_status_o;
    logic                     busy_o;

    modport master (
        input  cmd_start_i, argument_i, command_i, timeout_i, int_status_rst_i,
        input  finish_i, crc_ok_i, index_ok_i, response_i, dat0_i,
        output start_xfr_o, go_idle_o, cmd_o, with_response_o, long_response_o,
        output response_0_o, response_1_o, response_2_o, response_3_o,
        output int_status_o, busy_o
    );

    modport slave (
        output cmd_start_i, argument_i, command_i, timeout_i, int_status_rst_i,
        output finish_i, crc_ok_i, index_ok_i, response_i, dat0_i,
        input  start_xfr_o, go_idle_o, cmd_o, with_response_o, long_response_o,
        input  response_0_o, response_1_o, response_2_o, response_3_o,
        input  int_status_o, busy_o
    );
endinterface

// File: rtl/sd_cmd_master.sv
// SD command sequencer: start pulse -> PHY transaction -> response capture and status. Optional BUSY phase under SD_CMD_BUSY_CHECK_EN.
// Latency: start_xfr_o one cycle after cmd_start_i; status and busy_o drop one cycle after finish_i, timeout or DAT0 release.
// No backpressure: cmd_start_i is dropped while busy; the PHY handshake is pulse based (start_xfr_o / finish_i).
module sd_cmd_master #(
    parameter int CMD_REG_SIZE  = 14,
    parameter int CMD_TIMEOUT_W = 24,
    parameter int INT_CMD_SIZE  = 5
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    sd_cmd_master_if.master      bus
);
    localparam int CC    = 0;
    localparam int EI    = 1;
    localparam int CTE   = 2;
    localparam int CCRCE = 3;
    localparam int CIE   = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXECUTE = 2'd1;
`ifdef SD_CMD_BUSY_CHECK_EN
    localparam logic [1:0] ST_BUSY    = 2'd2;
`endif

    logic [1:0]               r_state;
    logic [CMD_TIMEOUT_W-1:0] r_counter;
    logic                     r_idx_chk;
    logic                     r_crc_chk;
`ifdef SD_CMD_BUSY_CHECK_EN
    logic                     r_busy_chk;
`endif
    logic                     r_start_xfr;
    logic                     r_go_idle;
    logic [39:0]              r_cmd;
    logic                     r_with_resp;
    logic                     r_long_resp;
    logic [31:0]              r_resp_0;
    logic [31:0]              r_resp_1;
    logic [31:0]              r_resp_2;
    logic [31:0]              r_resp_3;
    logic [INT_CMD_SIZE-1:0]  r_int_status;

    logic                     w_timeout_hit;
    logic                     w_crc_err;
    logic                     w_idx_err;
    logic                     w_resp_err;
    logic [INT_CMD_SIZE-1:0]  w_status_set;
    logic                     w_unused;

    assign w_timeout_hit = (bus.timeout_i != '0) && (r_counter >= bus.timeout_i);
    assign w_crc_err     = r_crc_chk && !bus.crc_ok_i;
    assign w_idx_err     = r_idx_chk && !bus.index_ok_i;
    assign w_resp_err    = w_crc_err || w_idx_err;

`ifdef SD_CMD_BUSY_CHECK_EN
    assign w_unused = ^bus.command_i[7:5];
`else
    assign w_unused = ^{bus.command_i[7:5], bus.command_i[2], bus.dat0_i};
`endif

    // Status bits raised this cycle; these win over a simultaneous clear.
    always_comb begin
        w_status_set = '0;
        case (r_state)
            ST_EXECUTE: begin
                if (bus.finish_i) begin
                    w_status_set[CCRCE] = w_crc_err;
                    w_status_set[CIE]   = w_idx_err;
                    w_status_set[EI]    = w_resp_err;
`ifdef SD_CMD_BUSY_CHECK_EN
                    w_status_set[CC]    = !w_resp_err && !r_busy_chk;
`else
                    w_status_set[CC]    = !w_resp_err;
`endif
                end else if (w_timeout_hit) begin
                    w_status_set[CTE] = 1'b1;
                    w_status_set[EI]  = 1'b1;
                end
            end
`ifdef SD_CMD_BUSY_CHECK_EN
            ST_BUSY: begin
                if (bus.dat0_i) begin
                    w_status_set[CC] = 1'b1;
                end else if (w_timeout_hit) begin
                    w_status_set[CTE] = 1'b1;
                    w_status_set[EI]  = 1'b1;
                end
            end
`endif
            default: w_status_set = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_counter    <= '0;
            r_idx_chk    <= 1'b0;
            r_crc_chk    <= 1'b0;
`ifdef SD_CMD_BUSY_CHECK_EN
            r_busy_chk   <= 1'b0;
`endif
            r_start_xfr  <= 1'b0;
            r_go_idle    <= 1'b0;
            r_cmd        <= '0;
            r_with_resp  <= 1'b0;
            r_long_resp  <= 1'b0;
            r_resp_0     <= '0;
            r_resp_1     <= '0;
            r_resp_2     <= '0;
            r_resp_3     <= '0;
            r_int_status <= '0;
        end else begin
            r_start_xfr  <= 1'b0;
            r_go_idle    <= 1'b0;
            r_int_status <= (bus.int_status_rst_i ? '0 : r_int_status) | w_status_set;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_start_i) begin
                        r_idx_chk    <= bus.command_i[4];
                        r_crc_chk    <= bus.command_i[3];
`ifdef SD_CMD_BUSY_CHECK_EN
                        r_busy_chk   <= bus.command_i[2];
`endif
                        r_cmd        <= {2'b01, bus.command_i[13:8], bus.argument_i};
                        r_with_resp  <= bus.command_i[1:0] != 2'b00;
                        r_long_resp  <= bus.command_i[1:0] == 2'b10;
                        r_start_xfr  <= 1'b1;
                        r_counter    <= '0;
                        r_int_status <= '0;
                        r_state      <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    r_counter <= r_counter + 1'b1;
                    if (bus.finish_i) begin
                        if (r_with_resp) begin
                            r_resp_0 <= bus.response_i[119:88];
                            if (r_long_resp) begin
                                r_resp_1 <= bus.response_i[87:56];
                                r_resp_2 <= bus.response_i[55:24];
                                r_resp_3 <= {bus.response_i[23:0], 8'h00};
                            end
                        end
                        r_counter <= '0;
`ifdef SD_CMD_BUSY_CHECK_EN
                        r_state   <= (!w_resp_err && r_busy_chk) ? ST_BUSY : ST_IDLE;
`else
                        r_state   <= ST_IDLE;
`endif
                    end else if (w_timeout_hit) begin
                        r_go_idle <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
`ifdef SD_CMD_BUSY_CHECK_EN
                // Card holds DAT0 low while busy; a timeout here needs no PHY abort.
                ST_BUSY: begin
                    r_counter <= r_counter + 1'b1;
                    if (bus.dat0_i || w_timeout_hit) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.start_xfr_o     = r_start_xfr;
    assign bus.go_idle_o       = r_go_idle;
    assign bus.cmd_o           = r_cmd;
    assign bus.with_response_o = r_with_resp;
    assign bus.long_response_o = r_long_resp;
    assign bus.response_0_o    = r_resp_0;
    assign bus.response_1_o    = r_resp_1;
    assign bus.response_2_o    = r_resp_2;
    assign bus.response_3_o    = r_resp_3;
    assign bus.int_status_o    = r_int_status;
    assign bus.busy_o          = r_state != ST_IDLE;
endmodule

// File: tb/tb_sd_cmd_master.sv
// Scoreboard bench for sd_cmd_master: driver pushes transaction-level expectations, a negedge monitor pops and compares.
module tb_sd_cmd_master;
    localparam int CRS = 14;
    localparam int TW  = 24;
    localparam int IW  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_cmd_master_if #(.CMD_REG_SIZE(CRS), .CMD_TIMEOUT_W(TW), .INT_CMD_SIZE(IW)) bus ();

    sd_cmd_master #(.CMD_REG_SIZE(CRS), .CMD_TIMEOUT_W(TW), .INT_CMD_SIZE(IW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus)
    );

    typedef struct packed {
        logic [39:0] cmd;
        logic        withr;
        logic        longr;
    } start_t;

    typedef struct packed {
        logic [4:0]       st;
        logic [3:0][31:0] r;
        logic             go;
        logic [31:0]      cycles;
    } done_t;

    start_t           exp_start[$];
    done_t            exp_done[$];
    logic [4:0]       exp_clr[$];
    logic [3:0][31:0] m_resp = '0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    logic prev_busy = 1'b0;
    logic prev_clr  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.start_xfr_o) begin
                if (exp_start.size() == 0) begin
                    fail_now("unexpected_start_xfr");
                end else begin
                    start_t s;
                    s = exp_start.pop_front();
                    check("cmd_o", bus.cmd_o, s.cmd);
                    check("with_response", bus.with_response_o, s.withr);
                    check("long_response", bus.long_response_o, s.longr);
                    start_cyc = cyc;
                end
            end
            if (prev_busy && !bus.busy_o) begin
                if (exp_done.size() == 0) begin
                    fail_now("unexpected_completion");
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("int_status", bus.int_status_o, d.st);
                    check("response_0", bus.response_0_o, d.r[0]);
                    check("response_1", bus.response_1_o, d.r[1]);
                    check("response_2", bus.response_2_o, d.r[2]);
                    check("response_3", bus.response_3_o, d.r[3]);
                    check("go_idle_at_end", bus.go_idle_o, d.go);
                    check("txn_cycles", cyc - start_cyc, d.cycles);
                end
            end else if (bus.go_idle_o) begin
                fail_now("stray_go_idle");
            end
            if (prev_clr) begin
                if (exp_clr.size() == 0) fail_now("unexpected_clear");
                else check("int_status_after_clear", bus.int_status_o, exp_clr.pop_front());
            end
        end
        prev_busy = bus.busy_o;
        prev_clr  = bus.int_status_rst_i;
    end

    // One command: finish_i arrives in execute cycle fin (0 = never); dat0 stays low for blow busy cycles.
    task automatic run_txn(input logic [13:0] cmd, input logic [31:0] arg, input logic [23:0] tmo,
                           input int fin, input logic crc, input logic idx,
                           input logic [119:0] resp, input int blow, input bit mid);
        start_t s;
        done_t  d;
        bit     tmo_hit;
        int     e_cyc;
        int     b_cyc;
        int     n;
        logic [4:0] st;
        logic [1:0] rt;
        rt = cmd[1:0];
        s.cmd   = {2'b01, cmd[13:8], arg};
        s.withr = (rt != 2'b00);
        s.longr = (rt == 2'b10);
        tmo_hit = (tmo != 0) && (fin == 0 || fin > int'(tmo) + 1);
        e_cyc   = tmo_hit ? int'(tmo) + 1 : fin;
        b_cyc   = 0;
        if (tmo_hit) begin
            st = 5'h06;
        end else begin
            if (rt == 2'b10) begin
                m_resp[0] = resp[119:88];
                m_resp[1] = resp[87:56];
                m_resp[2] = resp[55:24];
                m_resp[3] = {resp[23:0], 8'h00};
            end else if (rt != 2'b00) begin
                m_resp[0] = resp[119:88];
            end
            st = 5'h00;
            if (cmd[3] && !crc) st = st | 5'h0A;
            if (cmd[4] && !idx) st = st | 5'h12;
            if (st == 5'h00) begin
                st = 5'h01;
`ifdef SD_CMD_BUSY_CHECK_EN
                if (cmd[2]) begin
                    if (tmo == 0 || blow + 1 <= int'(tmo) + 1) begin
                        b_cyc = blow + 1;
                    end else begin
                        b_cyc = int'(tmo) + 1;
                        st = 5'h06;
                    end
                end
`endif
            end
        end
        d.st = st;
        d.r = m_resp;
        d.go = tmo_hit;
        d.cycles = e_cyc + b_cyc;
        exp_start.push_back(s);
        exp_done.push_back(d);

        bus.cmd_start_i = 1'b1;
        bus.command_i   = cmd;
        bus.argument_i  = arg;
        bus.timeout_i   = tmo;
        bus.response_i  = resp;
        bus.crc_ok_i    = crc;
        bus.index_ok_i  = idx;
        @(posedge clk); #1;
        bus.cmd_start_i = 1'b0;
        bus.command_i   = ~cmd;
        bus.argument_i  = ~arg;
        for (int c = 1; c <= e_cyc; c++) begin
            bus.finish_i    = !tmo_hit && (c == fin);
            if (bus.finish_i && blow > 0) bus.dat0_i = 1'b0;
            bus.cmd_start_i = mid && (c == 2);
            @(posedge clk); #1;
        end
        bus.finish_i    = 1'b0;
        bus.cmd_start_i = 1'b0;
        repeat (blow) begin
            @(posedge clk); #1;
        end
        bus.dat0_i = 1'b1;
        n = 0;
        while (bus.busy_o && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy_o) fail_now("busy_never_dropped");
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        exp_clr.push_back(5'h00);
        bus.int_status_rst_i = 1'b1;
        @(posedge clk); #1;
        bus.int_status_rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rnd;
        logic [13:0]  cmd;
        logic [23:0]  tmo;
        int           fin;
        bus.cmd_start_i      = 1'b0;
        bus.argument_i       = '0;
        bus.command_i        = '0;
        bus.timeout_i        = '0;
        bus.int_status_rst_i = 1'b0;
        bus.finish_i         = 1'b0;
        bus.crc_ok_i         = 1'b1;
        bus.index_ok_i       = 1'b1;
        bus.response_i       = '0;
        bus.dat0_i           = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_start_xfr", bus.start_xfr_o, 1'b0);
        check("reset_go_idle", bus.go_idle_o, 1'b0);
        check("reset_cmd_o", bus.cmd_o, 40'h0);
        check("reset_with_resp", bus.with_response_o, 1'b0);
        check("reset_long_resp", bus.long_response_o, 1'b0);
        check("reset_resp_words", {bus.response_0_o, bus.response_1_o, bus.response_2_o, bus.response_3_o}, 128'h0);
        check("reset_int_status", bus.int_status_o, 5'h00);
        check("reset_busy", bus.busy_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(14'h0201, 32'h01020304, 24'd0, 5, 1'b1, 1'b1, {32'h04050607, 88'h0}, 0, 1'b0);
        run_txn(14'h0219, 32'hA5A5_0001, 24'd0, 3, 1'b1, 1'b1, {32'h04050607, 88'h1234}, 0, 1'b0);
        run_txn(14'h021A, 32'h0000_0000, 24'd0, 4, 1'b1, 1'b1, 120'h0102030405060708090A0B0C0D0E0F, 0, 1'b0);
        run_txn(14'h0201, 32'hDEAD_BEEF, 24'd10, 0, 1'b1, 1'b1, 120'h0, 0, 1'b0);
        run_txn(14'h0201, 32'h0000_1000, 24'd0, 1000, 1'b1, 1'b1, {32'hCAFE_F00D, 88'h0}, 0, 1'b0);
        run_txn(14'h0219, 32'h1111_2222, 24'd0, 5, 1'b0, 1'b0, {32'h7777_8888, 88'h0}, 0, 1'b1);
        pulse_clear();
        run_txn(14'h0301, 32'h0, 24'd7, 8, 1'b1, 1'b1, {32'h0BAD_F00D, 88'h0}, 0, 1'b0);
        run_txn(14'h0301, 32'h0, 24'd7, 9, 1'b1, 1'b1, {32'h0BAD_0000, 88'h0}, 0, 1'b0);
        run_txn(14'h0205, 32'h55AA_55AA, 24'd0, 3, 1'b1, 1'b1, {32'h0909_0909, 88'h0}, 20, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            cmd = 14'($urandom);
            tmo = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 25));
            fin = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
            if (tmo == 0 && fin == 0) fin = $urandom_range(1, 30);
            run_txn(cmd, $urandom, tmo, fin, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    rnd[119:0], $urandom_range(0, 30), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) pulse_clear();
        end

        repeat (4) @(posedge clk);
        #1;
        check("pending_starts", exp_start.size(), 0);
        check("pending_completions", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
